// File: rtl/quad_phase_rx_pkg.sv
// Shared types and constants for the quad-phase frame receiver.
// Optional feature macro used by the top: QPFR_FRAME_CNT_EN.
package quad_phase_rx_pkg;

  // Receiver framing state: hunting for a strobe, or locked to frame boundaries
  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } qpfr_state_e;

  localparam int FRAME_BITS = 4;  // bits per lane per frame
  localparam int LANE_COUNT = 2;  // lane A and lane B

  // ui_in pin indices
  localparam int STB_BIT   = 0;
  localparam int LANEA_BIT = 1;
  localparam int LANEB_BIT = 2;
  localparam int CLR_BIT   = 3;

  // uio_out status bit indices
  localparam int VALID_BIT = 0;
  localparam int LOCK_BIT  = 1;
  localparam int ERR_BIT   = 2;

endpackage

// File: rtl/qpfr_sync.sv
// Single-bit multi-flop synchronizer for asynchronous link pins.
// Resets to 0 asynchronously; output is the last stage.
module qpfr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the pin value through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignment so every stage samples its predecessor's
      // pre-edge value; blocking here would collapse the chain into one flop.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/tt_um_quad_phase_frame_rx.sv
// Quad-phase two-lane frame receiver (TinyTapeout top).
// Strobe marks the 4th (last) bit of every frame; each frame of lane A and
// lane B bits, LSB first, is reassembled into uo_out = {B[3:0], A[3:0]}.
// Status on uio_out: [0] word_valid pulse, [1] locked, [2] sticky frame_err.
// Optional macro QPFR_FRAME_CNT_EN adds a 4-bit good-frame counter on
// uio_out[7:4] and drives all uio pins as outputs.
module tt_um_quad_phase_frame_rx
  import quad_phase_rx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int BITS_PER_LANE = FRAME_BITS  // pinout assumes 4 (8-bit word)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int                CNT_W    = $clog2(BITS_PER_LANE);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_LANE - 1);

  // Synchronized link pins
  logic [3:0] w_sync;
  logic       w_s_strobe;
  logic       w_s_a;
  logic       w_s_b;
  logic       w_s_clr;

  // FSM and datapath
  qpfr_state_e             r_state;
  qpfr_state_e             w_state_next;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_next;
  logic                    w_shift;
  logic                    w_load;
  logic                    w_err_set;
  logic [BITS_PER_LANE-2:0] r_lane_a;
  logic [BITS_PER_LANE-2:0] r_lane_b;
  logic [7:0]              w_word;
  logic [7:0]              r_word;
  logic                    r_valid;
  logic                    r_err;
  logic [3:0]              w_cnt_nib;
  logic [7:0]              w_status;
  logic                    w_unused;

  // One synchronizer per used input pin: strobe, lane A, lane B, err_clear
  for (genvar g = 0; g < 4; g++) begin : g_sync
    qpfr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (ui_in[g]),
      .o_q  (w_sync[g])
    );
  end

  assign w_s_strobe = w_sync[STB_BIT];
  assign w_s_a      = w_sync[LANEA_BIT];
  assign w_s_b      = w_sync[LANEB_BIT];
  assign w_s_clr    = w_sync[CLR_BIT];

  // FSM state and bit-position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state logic: frame boundary tracking and error detection
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_state_next = r_state;
    w_count_next = r_count;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_err_set    = 1'b0;
    if (!ena) begin
      w_state_next = HUNT;
      w_count_next = '0;
    end else begin
      unique case (r_state)
        HUNT: begin
          // Data is discarded until a strobe marks a frame boundary
          if (w_s_strobe) begin
            w_state_next = LOCK;
            w_count_next = '0;
          end
        end
        LOCK: begin
          w_shift = 1'b1;
          if (r_count == LAST_BIT) begin
            w_count_next = '0;
            if (w_s_strobe) begin
              w_load = 1'b1;
            end else begin
              // Missing strobe: boundary lost, go back to hunting
              w_err_set    = 1'b1;
              w_state_next = HUNT;
            end
          end else if (w_s_strobe) begin
            // Early strobe: drop the partial frame and realign on this strobe
            w_err_set    = 1'b1;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  // Completed word: current (last) bit on top of the three shifted-in bits
  assign w_word = {w_s_b, r_lane_b, w_s_a, r_lane_a};

  // Lane shift registers, output word, valid pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_a <= '0;
      r_lane_b <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // LSB arrives first, so shift right; after three shifts bit 0 sits at [0]
      if (w_shift) begin
        r_lane_a <= {w_s_a, r_lane_a[BITS_PER_LANE-2:1]};
        r_lane_b <= {w_s_b, r_lane_b[BITS_PER_LANE-2:1]};
      end
      if (w_load) begin
        r_word <= w_word;
      end
      r_valid <= w_load;
      // Set has priority over clear; the flag is frozen while the tile is disabled
      if (ena) begin
        if (w_err_set) begin
          r_err <= 1'b1;
        end else if (w_s_clr) begin
          r_err <= 1'b0;
        end
      end
    end
  end

`ifdef QPFR_FRAME_CNT_EN
  logic [3:0] r_frame_cnt;

  // Good-frame counter, wraps naturally at 4 bits; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_frame_cnt <= r_frame_cnt + 4'd1;
    end
  end

  assign w_cnt_nib = r_frame_cnt;
  assign uio_oe    = 8'hFF;
`else
  assign w_cnt_nib = 4'h0;
  assign uio_oe    = 8'h0F;
`endif

  // Status byte assembly
  always_comb begin
    w_status            = '0;
    w_status[VALID_BIT] = r_valid;
    w_status[LOCK_BIT]  = (r_state == LOCK);
    w_status[ERR_BIT]   = r_err;
    w_status[7:4]       = w_cnt_nib;
  end

  assign uo_out  = r_word;
  assign uio_out = w_status;

  // Pins with no function in this tile
  assign w_unused = ^{ui_in[7:4], uio_in};

endmodule
